demux_1to4_stream: RTL

//   Registered 1-to-4 stream demultiplexer with packet-locked routing; counterpart of the
//   4:1 select mux. Accepts one valid/ready input stream and steers each packet to one of

---
 rtl/demux_1to4_stream.sv | 111 +++++++++++
 1 files changed

// File: rtl/demux_1to4_stream.sv
// demux_1to4_stream
//   Registered 1-to-4 stream demultiplexer with packet-locked routing.
//   One valid/ready input stream is steered, packet by packet, to one of four
//   output channels. The channel is picked by {s1,s0} on a packet's first beat
//   and held until that packet's last beat. Each channel owns a one-entry
//   register slot, so a stalled channel only blocks packets routed to it.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   i_data   input payload (DATA_W bits)
//   i_valid  input beat valid
//   i_last   input beat is the last of its packet
//   i_ready  input beat accepted when i_valid && i_ready
//   s0, s1   channel select {s1,s0}, only looked at on a packet's first beat
//   y_data   channel k payload at y_data[k*DATA_W +: DATA_W]
//   y_valid  per-channel valid
//   y_last   per-channel last flag
//   y_ready  per-channel downstream ready
//   busy     high while a packet is in progress (lock held)
module demux_1to4_stream #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_valid,
  input  logic                  i_last,
  output logic                  i_ready,
  input  logic                  s0,
  input  logic                  s1,
  output logic [4*DATA_W-1:0]   y_data,
  output logic [3:0]            y_valid,
  output logic [3:0]            y_last,
  input  logic [3:0]            y_ready,
  output logic                  busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]        state_q;
  logic [1:0]        sel_q;
  logic [1:0]        tgt;
  logic [3:0]        slot_free;
  logic              accept;

  logic [DATA_W-1:0] data_p1 [4];
  logic [3:0]        vld_p1;
  logic [3:0]        last_p1;

  // Stage p0: route decision. While a packet is in progress the live select
  // pins are ignored and the locked channel is used instead. A slot is free if
  // empty or being drained this cycle, which is the only combinational path
  // from the outputs back to i_ready.
  always_comb begin
    tgt       = (state_q == BUSY) ? sel_q : {s1, s0};
    slot_free = ~vld_p1 | y_ready;
    i_ready   = slot_free[tgt];
    accept    = i_valid & i_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (!i_last) begin
            sel_q   <= tgt;
            state_q <= BUSY;
          end
        end
        default: begin
          if (i_last) state_q <= IDLE;
        end
      endcase
    end
  end

  // Stage p1: per-channel output slots. A fill wins over a drain so that a
  // simultaneous drain+fill keeps the slot valid with the new beat. Payload is
  // only written on a fill, so it holds while stalled or empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 4'b0000;
      last_p1 <= 4'b0000;
      for (int k = 0; k < 4; k++) data_p1[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept && (tgt == 2'(k))) begin
          vld_p1[k]  <= 1'b1;
          data_p1[k] <= i_data;
          last_p1[k] <= i_last;
        end else if (y_ready[k]) begin
          vld_p1[k]  <= 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_out
    assign y_data[k*DATA_W +: DATA_W] = data_p1[k];
  end

  assign y_valid = vld_p1;
  assign y_last  = last_p1;
  assign busy    = (state_q == BUSY);

endmodule
